uart_msg_encoder: RTL

//  Transmit-side framer for the UART message protocol. Takes a parallel payload plus a

---
 rtl/uart_msg_encoder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_msg_encoder.sv
// UART message framer: emits SYNC, BCNT, body bytes, TAIL with SP_ESC byte stuffing.
// Optional macro TX_CHECKSUM_EN: tail is XOR of BCNT and payload instead of SP_END.
module uart_msg_encoder #(
  parameter int unsigned MAXBYTES    = 10,
  parameter logic [7:0]  SP_SYNC     = 8'h7E,
  parameter logic [7:0]  SP_ESC      = 8'hFE,
  parameter logic [7:0]  SP_END      = 8'h03,
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  msg_send,
  input  logic [7:0]            msg_len,
  input  logic [8*MAXBYTES-1:0] msg_data,
  input  logic                  tx_empty,
  output logic [7:0]            tx_data,
  output logic                  ld_tx_data,
  output logic                  tx_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SYNC, BCNT, BODY, TAIL} phase_t;
  typedef enum logic {ISSUE, ACK} emit_t;

  phase_t                phase, phaseNext;
  emit_t                 emitSt, emitNext;
  logic [8*MAXBYTES-1:0] payload;
  logic [7:0]            len, idx, idxNext;
  logic                  escDone, escDoneNext;
  logic [CNT_W-1:0]      ackCnt, ackCntNext;
  logic [7:0]            bodyByte, tailByte, curByte, outByte;
  logic                  needEsc, lenOk, accept, ldNext, doneNext, errNext;

  always_comb begin
    bodyByte = '0;
    for (int unsigned i = 0; i < MAXBYTES; i++)
      if (idx == 8'(i)) bodyByte = payload[8*(MAXBYTES-1-i) +: 8];
`ifdef TX_CHECKSUM_EN
    tailByte = len;
    for (int unsigned i = 0; i < MAXBYTES; i++)
      if (8'(i) < len) tailByte = tailByte ^ payload[8*(MAXBYTES-1-i) +: 8];
`else
    tailByte = SP_END;
`endif
    case (phase)
      SYNC:    curByte = SP_SYNC;
      BCNT:    curByte = len;
      BODY:    curByte = bodyByte;
      TAIL:    curByte = tailByte;
      default: curByte = '0;
    endcase
    // escDone marks that the prefix for the current byte was already accepted
    needEsc = (phase != SYNC) && !escDone && (curByte == SP_SYNC || curByte == SP_ESC);
    outByte = needEsc ? SP_ESC : curByte;
    lenOk   = (msg_len != 8'd0) && (msg_len <= 8'(MAXBYTES));
  end

  always_comb begin
    phaseNext   = phase;
    emitNext    = emitSt;
    idxNext     = idx;
    escDoneNext = escDone;
    ackCntNext  = ackCnt;
    accept      = 1'b0;
    ldNext      = 1'b0;
    doneNext    = 1'b0;
    errNext     = 1'b0;
    case (phase)
      IDLE: begin
        if (msg_send) begin
          if (lenOk) begin
            accept      = 1'b1;
            phaseNext   = SYNC;
            emitNext    = ISSUE;
            idxNext     = '0;
            escDoneNext = 1'b0;
          end else begin
            errNext = 1'b1;
          end
        end
      end
      default: begin
        if (emitSt == ISSUE) begin
          if (tx_empty) begin
            ldNext     = 1'b1;
            emitNext   = ACK;
            ackCntNext = '0;
          end
        end else if (!tx_empty) begin
          emitNext = ISSUE;
          if (needEsc) begin
            escDoneNext = 1'b1;
          end else begin
            escDoneNext = 1'b0;
            case (phase)
              SYNC: phaseNext = BCNT;
              BCNT: begin
                phaseNext = BODY;
                idxNext   = '0;
              end
              BODY: begin
                if (idx == len - 8'd1) phaseNext = TAIL;
                else idxNext = idx + 8'd1;
              end
              TAIL: begin
                phaseNext = IDLE;
                doneNext  = 1'b1;
              end
              default: phaseNext = IDLE;
            endcase
          end
        end else if (ackCnt == CNT_W'(ACK_TIMEOUT)) begin
          phaseNext = IDLE;
          errNext   = 1'b1;
        end else begin
          ackCntNext = ackCnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= IDLE;
      emitSt     <= ISSUE;
      payload    <= '0;
      len        <= '0;
      idx        <= '0;
      escDone    <= 1'b0;
      ackCnt     <= '0;
      tx_data    <= '0;
      ld_tx_data <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      phase      <= phaseNext;
      emitSt     <= emitNext;
      idx        <= idxNext;
      escDone    <= escDoneNext;
      ackCnt     <= ackCntNext;
      ld_tx_data <= ldNext;
      done       <= doneNext;
      err        <= errNext;
      if (ldNext) tx_data <= outByte;
      if (accept) begin
        payload <= msg_data;
        len     <= msg_len;
      end
    end
  end

  assign busy      = (phase != IDLE);
  assign tx_enable = busy;

endmodule
